// File: rtl/mem_arbiter.sv
// Two-master round-robin write arbiter in front of mem_ctrl, with a bounded lock.
// Every output is a flop; a master is masked for one cycle after its ack so it is never served twice.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_lock,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_data,
    output logic                  m0_ack,
    input  logic                  m1_req,
    input  logic                  m1_lock,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_data,
    output logic                  m1_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  grant_id,
    output logic                  busy
);

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    logic                  m0_ack_q, m0_ack_d;
    logic                  m1_ack_q, m1_ack_d;
    logic                  mem_we_q, mem_we_d;
    logic                  busy_q, busy_d;
    logic                  grant_id_q, grant_id_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  last_grant_q, last_grant_d;
    logic                  lock_valid_q, lock_valid_d;
    logic                  lock_owner_q, lock_owner_d;
    logic [3:0]            hold_cnt_q, hold_cnt_d;

    logic elig0, elig1;
    logic owner_elig, other_elig;
    logic lock_hit, lock_override;
    logic grant_valid, grant_sel;
    logic sel_lock, sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    always_comb begin
        elig0      = m0_req & ~m0_ack_q;
        elig1      = m1_req & ~m1_ack_q;
        owner_elig = lock_owner_q ? elig1 : elig0;
        other_elig = lock_owner_q ? elig0 : elig1;

        // The lock wins unless it has used up its hold budget while the other master waits.
        lock_hit      = lock_valid_q & owner_elig & (~other_elig | (hold_cnt_q < MAX_HOLD_C));
        lock_override = lock_valid_q & owner_elig & other_elig & ~(hold_cnt_q < MAX_HOLD_C);

        grant_valid = 1'b0;
        grant_sel   = 1'b0;
        if (lock_hit) begin
            grant_valid = 1'b1;
            grant_sel   = lock_owner_q;
        end else if (elig0 ^ elig1) begin
            grant_valid = 1'b1;
            grant_sel   = elig1;
        end else if (elig0 & elig1) begin
            grant_valid = 1'b1;
            grant_sel   = ~last_grant_q;
        end

        sel_lock = grant_sel ? m1_lock : m0_lock;
        sel_we   = grant_sel ? m1_we   : m0_we;
        sel_addr = grant_sel ? m1_addr : m0_addr;
        sel_data = grant_sel ? m1_data : m0_data;
    end

    always_comb begin
        m0_ack_d     = grant_valid & ~grant_sel;
        m1_ack_d     = grant_valid & grant_sel;
        mem_we_d     = grant_valid & sel_we;
        busy_d       = grant_valid;
        grant_id_d   = grant_id_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        last_grant_d = last_grant_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        hold_cnt_d   = hold_cnt_q;

        if (grant_valid) begin
            grant_id_d   = grant_sel;
            mem_addr_d   = sel_addr;
            mem_data_d   = sel_data;
            last_grant_d = grant_sel;

            if (lock_override || !sel_lock) begin
                lock_valid_d = 1'b0;
                hold_cnt_d   = 4'd0;
            end else begin
                lock_valid_d = 1'b1;
                lock_owner_d = grant_sel;
                if (lock_valid_q && (lock_owner_q == grant_sel)) begin
                    hold_cnt_d = (hold_cnt_q == 4'd15) ? 4'd15 : hold_cnt_q + 4'd1;
                end else begin
                    hold_cnt_d = 4'd1;
                end
            end
        end
    end

    // last_grant resets to master 1 so that master 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            grant_id_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            last_grant_q <= 1'b1;
            lock_valid_q <= 1'b0;
            lock_owner_q <= 1'b0;
            hold_cnt_q   <= 4'd0;
        end else begin
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            mem_we_q     <= mem_we_d;
            busy_q       <= busy_d;
            grant_id_q   <= grant_id_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            last_grant_q <= last_grant_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign mem_we   = mem_we_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;

endmodule
